// File: rtl/wb_port_arbiter.sv
// Purpose : arbitrates the single RegFile write port between source A (ALU/CSR) and source B (load/mul/div).
// Latency : 1 cycle from granted request to wb_en/rd_index/wb_data; busy-bit set/clear visible after the next edge.
// Backpress: A is never stalled; B is stalled by b_ready=0 and must hold its request; A is throttled via a_hold.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   a_valid, a_rd, a_data         source A writeback request (always wins)
//   a_hold                        asks upstream to withhold A this cycle so B can drain
//   b_valid, b_ready, b_rd, b_data source B writeback request with handshake
//   sb_set, sb_set_rd             decode marks a register as owed by B
//   q_rs1/q_rs2/q_rd -> *_busy    hazard queries against the busy-bit scoreboard
//   wb_en, rd_index, wb_data      registered RegFile write port
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4    // legal range 1..15 (4-bit counter)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  a_valid,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] a_rd,
  input  logic [XLEN-1:0]                       a_data,
  output logic                                  a_hold,
  input  logic                                  b_valid,
  output logic                                  b_ready,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] b_rd,
  input  logic [XLEN-1:0]                       b_data,
  input  logic                                  sb_set,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] sb_set_rd,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] q_rs1,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] q_rs2,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] q_rd,
  output logic                                  rs1_busy,
  output logic                                  rs2_busy,
  output logic                                  rd_busy,
  output logic                                  wb_en,
  output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] rd_index,
  output logic [XLEN-1:0]                       wb_data
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef struct packed {
    logic [IW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  wb_req_t         gnt_req;
  logic            gnt_vld;
  logic            b_gnt;
  logic [3:0]      starve_cnt;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Fixed priority: A wins whenever it is valid, even under a_hold.
  always_comb begin
    b_gnt        = b_valid && !a_valid;
    gnt_vld      = a_valid || b_valid;
    gnt_req.rd   = a_valid ? a_rd   : b_rd;
    gnt_req.data = a_valid ? a_data : b_data;
  end

  assign b_ready = b_gnt;
  assign a_hold  = (starve_cnt == 4'(STARVE_MAX));

  // Busy-bit next state: clear on B grant, then set so a same-cycle
  // set of the same register wins. x0 is never owed.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (b_gnt && (b_rd == IW'(r)))
        busy_d[r] = 1'b0;
      if (sb_set && (sb_set_rd == IW'(r)))
        busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign rs1_busy = busy_q[q_rs1];
  assign rs2_busy = busy_q[q_rs2];
  assign rd_busy  = busy_q[q_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en      <= 1'b0;
      rd_index   <= '0;
      wb_data    <= '0;
      starve_cnt <= 4'd0;
      busy_q     <= '0;
    end else begin
      // x0 requests are consumed without a write, but index/data still load.
      wb_en <= gnt_vld && (gnt_req.rd != '0);
      if (gnt_vld) begin
        rd_index <= gnt_req.rd;
        wb_data  <= gnt_req.data;
      end

      // B blocked implies A valid, so only a blocked B advances the counter.
      if (!b_valid || b_gnt)
        starve_cnt <= 4'd0;
      else if (starve_cnt != 4'(STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;

      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_hold;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  wb_port_arbiter #(.XLEN(32), .NREG(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_hold(a_hold),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every RegFile write must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (rst_n && wb_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd_index=%0d wb_data=0x%0h with nothing expected at %0t",
                 rd_index, wb_data, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_rd_index", {27'd0, rd_index}, {27'd0, w.rd});
        chk("wr_data", wb_data, w.data);
      end
    end
  end

  // Upstream contract: A must be withheld while a_hold is raised.
  always @(negedge clk) begin
    #2;
    if (rst_n && a_hold && a_valid) begin
      errors++;
      $display("FAIL a_hold_contract: a_valid=1 while a_hold=1 at %0t", $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1111_2222;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    sb_set = 1'b1; sb_set_rd = 5'd4;
    q_rs1 = 5'd4; q_rs2 = 5'd3; q_rd = 5'd4;

    // Reset held for two edges with A and sb_set active.
    step(); step();
    #1;
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_rd_index", {27'd0, rd_index}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_a_hold", {31'd0, a_hold}, 32'd0);
    rst_n = 1'b1; a_valid = 1'b0; sb_set = 1'b0;

    // A only: write to x5, then an x0 write that must be dropped.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    step();
    a_rd = 5'd0; a_data = 32'h0000_1234;
    step();
    a_valid = 1'b0;
    #1;
    chk("a_x0_wb_en", {31'd0, wb_en}, 32'd0);

    // Contention: B blocked for 4 cycles, a_hold in cycle 5.
    b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hB0B0_B0B0;
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1'b1; a_rd = 5'(i); a_data = 32'hA000_0000 + 32'(i);
      #1;
      chk("cont_b_ready", {31'd0, b_ready}, 32'd0);
      chk("cont_a_hold", {31'd0, a_hold}, 32'd0);
      expect_wr(5'(i), 32'hA000_0000 + 32'(i));
      step();
    end
    chk("starve_a_hold", {31'd0, a_hold}, 32'd1);
    a_valid = 1'b0;
    #1;
    chk("starve_b_ready", {31'd0, b_ready}, 32'd1);
    expect_wr(5'd12, 32'hB0B0_B0B0);
    step();
    b_valid = 1'b0;
    #1;
    chk("starve_cleared", {31'd0, a_hold}, 32'd0);

    // Scoreboard set at t, clear by B grant at t+3.
    sb_set = 1'b1; sb_set_rd = 5'd7; q_rs1 = 5'd7;
    #1;
    chk("sb_same_cycle_reads0", {31'd0, rs1_busy}, 32'd0);
    step();
    sb_set = 1'b0;
    #1;
    chk("sb_busy_t1", {31'd0, rs1_busy}, 32'd1);
    step();
    step();
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h7777_7777;
    #1;
    chk("sb_b_ready", {31'd0, b_ready}, 32'd1);
    chk("sb_busy_t3", {31'd0, rs1_busy}, 32'd1);
    expect_wr(5'd7, 32'h7777_7777);
    step();
    b_valid = 1'b0;
    #1;
    chk("sb_cleared_t4", {31'd0, rs1_busy}, 32'd0);

    // Same-cycle set/clear of x9: set wins, write still issued.
    q_rs2 = 5'd9; q_rd = 5'd9;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    step();
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999_0009;
    expect_wr(5'd9, 32'h9999_0009);
    step();
    sb_set = 1'b0; b_valid = 1'b0;
    #1;
    chk("setclr_rd_busy", {31'd0, rd_busy}, 32'd1);
    chk("setclr_rs2_busy", {31'd0, rs2_busy}, 32'd1);
    b_valid = 1'b1; b_data = 32'h9999_000A;
    expect_wr(5'd9, 32'h9999_000A);
    step();
    b_valid = 1'b0;
    #1;
    chk("clr9_rd_busy", {31'd0, rd_busy}, 32'd0);

    // x0: never busy, B request handshaken without a write.
    sb_set = 1'b1; sb_set_rd = 5'd0; q_rs1 = 5'd0;
    step();
    sb_set = 1'b0;
    #1;
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_AAAA;
    #1;
    chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    #1;
    chk("x0_wb_en", {31'd0, wb_en}, 32'd0);
    chk("x0_rd_index", {27'd0, rd_index}, 32'd0);
    step();
    #1;
    chk("idle_hold_rd_index", {27'd0, rd_index}, 32'd0);
    chk("idle_hold_wb_data", wb_data, 32'h0000_AAAA);

    step(); step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
